// File: rtl/cpu_bus_bridge.sv
// Bridges the CPU's four-phase external bus onto block RAM, an ack-based I/O peripheral,
// or an unmapped-access error path, with sticky error reporting.
module cpu_bus_bridge #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RAM_TOP    = 32'h0001_0000,
  parameter int unsigned       RAM_AW     = 16,
  parameter int unsigned       RAM_LAT    = 1,
  parameter logic [ADDR_W-1:0] IO_BASE    = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] IO_SIZE    = 32'h0001_0000,
  parameter int unsigned       IO_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bus_clk,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_data,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_data_ready,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_io_stb,
  output logic              o_io_we,
  output logic [ADDR_W-1:0] o_io_addr,
  output logic [DATA_W-1:0] o_io_wdata,
  input  logic              i_io_ack,
  input  logic [DATA_W-1:0] i_io_rdata,
  output logic              o_err_unmapped,
  output logic              o_err_timeout,
  output logic [ADDR_W-1:0] o_err_addr
);

  localparam logic [2:0] LatInit = 3'(RAM_LAT);
  localparam logic [7:0] TmoLast = 8'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRamRd,
    StIoWait,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              ready_q, ready_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              io_stb_q, io_stb_d;
  logic              io_we_q, io_we_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic              err_unm_q, err_unm_d;
  logic              err_tmo_q, err_tmo_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [ADDR_W-1:0] io_off;
  logic              ram_hit;
  logic              io_hit;

  // Offset-based I/O test avoids overflow of IO_BASE + IO_SIZE at the top of the map.
  assign io_off  = i_bus_addr - IO_BASE;
  assign ram_hit = i_bus_addr < RAM_TOP;
  assign io_hit  = (i_bus_addr >= IO_BASE) && (io_off < IO_SIZE);

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    req_addr_d  = req_addr_q;
    bus_data_d  = bus_data_q;
    ready_d     = ready_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    io_stb_d    = io_stb_q;
    io_we_d     = io_we_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    err_unm_d   = err_unm_q;
    err_tmo_d   = err_tmo_q;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      StIdle: begin
        if (i_bus_clk) begin
          req_addr_d = i_bus_addr;
          bus_data_d = '0;
          if (ram_hit) begin
            ram_addr_d = i_bus_addr[RAM_AW-1:0];
            if (i_bus_we) begin
              ram_we_d    = 1'b1;
              ram_wdata_d = i_bus_data;
              state_d     = StDone;
            end else begin
              lat_cnt_d = LatInit;
              state_d   = StRamRd;
            end
          end else if (io_hit) begin
            io_stb_d   = 1'b1;
            io_we_d    = i_bus_we;
            io_addr_d  = io_off;
            io_wdata_d = i_bus_data;
            tmo_cnt_d  = '0;
            state_d    = StIoWait;
          end else begin
            err_unm_d  = 1'b1;
            err_addr_d = i_bus_addr;
            state_d    = StDone;
          end
        end
      end

      StRamRd: begin
        // The RAM samples the address one clock after acceptance, hence one extra wait.
        if (lat_cnt_q == '0) begin
          bus_data_d = i_ram_rdata;
          ready_d    = 1'b1;
          state_d    = StDone;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end

      StIoWait: begin
        if (i_io_ack) begin
          if (!io_we_q) begin
            bus_data_d = i_io_rdata;
          end
          io_stb_d = 1'b0;
          io_we_d  = 1'b0;
          ready_d  = 1'b1;
          state_d  = StDone;
        end else if (tmo_cnt_q == TmoLast) begin
          io_stb_d   = 1'b0;
          io_we_d    = 1'b0;
          bus_data_d = '1;
          err_tmo_d  = 1'b1;
          err_addr_d = req_addr_q;
          ready_d    = 1'b1;
          state_d    = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      StDone: begin
        // Writes and unmapped accesses arrive here with ready still low.
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (!i_bus_clk) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      req_addr_q  <= '0;
      bus_data_q  <= '0;
      ready_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      io_stb_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      err_unm_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      req_addr_q  <= req_addr_d;
      bus_data_q  <= bus_data_d;
      ready_q     <= ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      io_stb_q    <= io_stb_d;
      io_we_q     <= io_we_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      err_unm_q   <= err_unm_d;
      err_tmo_q   <= err_tmo_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign o_bus_data       = bus_data_q;
  assign o_bus_data_ready = ready_q;
  assign o_ram_we         = ram_we_q;
  assign o_ram_addr       = ram_addr_q;
  assign o_ram_wdata      = ram_wdata_q;
  assign o_io_stb         = io_stb_q;
  assign o_io_we          = io_we_q;
  assign o_io_addr        = io_addr_q;
  assign o_io_wdata       = io_wdata_q;
  assign o_err_unmapped   = err_unm_q;
  assign o_err_timeout    = err_tmo_q;
  assign o_err_addr       = err_addr_q;

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Sits directly downstream of the CPU core's external bus port. Consumes the CPU's four-phase request (bus_clk/we/addr/data) and returns read data plus data-ready.
- Decodes each address into one of three regions and runs the access: internal block RAM with fixed read latency, an external I/O peripheral with strobe/ack and timeout, or unmapped.
- Reports unmapped and timed-out accesses through sticky error outputs.

Parameters:
- ADDR_W, 32, address width; matches the CPU bus address.
- DATA_W, 32, data width; matches the CPU bus data.
- RAM_TOP, 32'h0001_0000, RAM region is 0 <= addr < RAM_TOP.
- RAM_AW, 16, RAM word-address width; RAM address is addr[RAM_AW-1:0].
- RAM_LAT, 1, RAM read latency in clocks (1..4).
- IO_BASE, 32'hFFFF_0000, first I/O address.
- IO_SIZE, 32'h0001_0000, I/O region length; I/O region is IO_BASE <= addr < IO_BASE+IO_SIZE.
- IO_TIMEOUT, 255, maximum clocks to wait for i_io_ack (8-bit counter).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_bus_clk  in  1  CPU request level; high = request active.
- i_bus_we  in  1  1 = write, 0 = read.
- i_bus_addr  in  ADDR_W  request address.
- i_bus_data  in  DATA_W  write data.
- o_bus_data  out  DATA_W  read data to CPU.
- o_bus_data_ready  out  1  completion to CPU.
- o_ram_we  out  1  RAM write enable.
- o_ram_addr  out  RAM_AW  RAM address.
- o_ram_wdata  out  DATA_W  RAM write data.
- i_ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT clocks after the address.
- o_io_stb  out  1  I/O strobe.
- o_io_we  out  1  I/O write.
- o_io_addr  out  ADDR_W  I/O offset (addr - IO_BASE).
- o_io_wdata  out  DATA_W  I/O write data.
- i_io_ack  in  1  I/O completion.
- i_io_rdata  in  DATA_W  I/O read data, valid with ack.
- o_err_unmapped  out  1  sticky: an unmapped access occurred.
- o_err_timeout  out  1  sticky: an I/O access timed out.
- o_err_addr  out  ADDR_W  address of the most recent erroring access.

Behaviour:
- Reset:
  - Single clock i_clk; reset i_rst is synchronous, active-high.
  - Reset forces state IDLE and all outputs to 0.
  - Reset mid-access aborts the access: strobe, we and ready drop the next clock, and the pending ack is ignored.
- Handshake (four-phase):
  - CPU raises i_bus_clk and holds addr/we/data stable until it sees o_bus_data_ready.
  - CPU then drops i_bus_clk.
  - Bridge holds o_bus_data_ready and o_bus_data until i_bus_clk is low, then drops ready on the next clock.
  - A new request is accepted only from IDLE.
- FSM states: IDLE, RAM_RD, IO_WAIT, DONE.
- IDLE, i_bus_clk=1: capture we/addr/data and decode. Priority is RAM over IO if regions overlap.
  - RAM write: o_ram_we=1 for exactly one clock, then DONE. Ready rises 1 clock after acceptance.
  - RAM read: drive o_ram_addr, load latency counter, go to RAM_RD.
  - IO: o_io_stb=1, o_io_we, o_io_addr, o_io_wdata; clear timeout counter; go to IO_WAIT.
  - Unmapped: o_bus_data=0, set o_err_unmapped, o_err_addr=addr, go to DONE.
- RAM_RD: after RAM_LAT clocks, latch i_ram_rdata into o_bus_data and go to DONE. Ready is first seen RAM_LAT+1 clocks after acceptance.
- IO_WAIT:
  - o_io_stb held high.
  - On i_io_ack: read latches i_io_rdata; strobe drops; go to DONE.
  - Counter reaching IO_TIMEOUT with no ack: strobe drops, o_bus_data = all ones, set o_err_timeout and o_err_addr, go to DONE.
  - Ack arriving on the same clock as timeout wins; no error is raised.
  - Ack in IDLE/DONE is ignored.
- DONE: o_bus_data_ready=1. When i_bus_clk=0, go to IDLE with ready=0.
  - Minimum spacing between accepted requests: one IDLE clock.
- Writes return o_bus_data=0.
- Error flags are sticky until reset. A later error overwrites o_err_addr.

Test Plan:
- RAM write/read: write addr 0x0000_1234 data 0xDEADBEEF, then read it back (RAM_LAT=1) -> o_ram_we pulses 1 clock at 0x1234; read ready 2 clocks after acceptance with data 0xDEADBEEF; ready held until i_bus_clk drops.
- I/O read: read 0xFFFF_0010 with ack after 5 clocks, rdata 0x0000_00A5 -> o_io_stb high 5 clocks, o_io_addr=0x10, o_bus_data=0xA5, no error flags.
- I/O timeout: read 0xFFFF_0020, never ack -> strobe drops after 255 clocks, o_bus_data=0xFFFFFFFF, o_err_timeout=1, o_err_addr=0xFFFF_0020.
- Unmapped: write to 0x0002_0000 -> ready 1 clock after acceptance, no RAM/IO activity, o_err_unmapped=1, o_err_addr=0x0002_0000.
- Ack/timeout collision: ack on exactly the 255th wait clock -> data taken from i_io_rdata, o_err_timeout stays 0.
- Reset mid-I/O: assert i_rst during IO_WAIT -> next clock all outputs 0 and state IDLE; a late ack is ignored; a following RAM read completes normally.
